// File: rtl/johnson_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module   : johnson_phase_monitor
// Brief    : Decodes a sampled Johnson code into a phase index and reports
//            legality, sequence errors, wrap pulses and lock status.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_phase_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERRCNT_W = 8,
    localparam int PW      = $clog2(2 * WIDTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [WIDTH-1:0]    Q_IN,
    input  logic                EN,
    input  logic                CLR_ERR,
    output logic [PW-1:0]       PHASE,
    output logic                PHASE_VLD,
    output logic                LEGAL,
    output logic                SEQ_ERR,
    output logic                WRAP,
    output logic                LOCKED,
    output logic [ERRCNT_W-1:0] ERR_CNT
);

    localparam int RW = 4;
    localparam logic [1:0]          c_UNLOCKED = 2'd0;
    localparam logic [1:0]          c_LOCKING  = 2'd1;
    localparam logic [1:0]          c_LOCKED   = 2'd2;
    localparam logic [RW-1:0]       c_lock_cnt = RW'(LOCK_CNT);
    localparam logic [ERRCNT_W-1:0] c_err_max  = '1;

    logic [WIDTH-1:0]    r_q;
    logic                r_en;
    logic [1:0]          r_state;
    logic [RW-1:0]       r_run;
    logic [PW-1:0]       r_phase;
    logic                r_vld;
    logic                r_legal;
    logic                r_seq_err;
    logic                r_wrap;
    logic                r_locked;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0]    w_q_inv;
    logic [PW-1:0]       w_ones;
    logic                w_legal;
    logic [PW-1:0]       w_phase;
    logic                w_inseq;
    logic [1:0]          w_state_nxt;
    logic [RW-1:0]       w_run_nxt;
    logic                w_seq_err_nxt;
    logic                w_wrap_nxt;
    logic [ERRCNT_W-1:0] w_err_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q  <= '0;
            r_en <= 1'b0;
        end else begin
            r_q  <= Q_IN;
            r_en <= EN;
        end
    end

    // Legal codes are a run of ones from the LSB (MSB=0) or from the MSB
    // (MSB=1); the phase follows from the population count. 2*WIDTH is a
    // power of two, so it wraps to zero in PW bits.
    always_comb begin
        w_ones  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + PW'(r_q[i]);
        end
        w_q_inv = ~r_q;
        if (r_q[WIDTH-1]) begin
            w_legal = ((w_q_inv & (w_q_inv + WIDTH'(1))) == '0);
            w_phase = PW'(0) - w_ones;
        end else begin
            w_legal = ((r_q & (r_q + WIDTH'(1))) == '0);
            w_phase = w_ones;
        end
    end

    assign w_inseq = w_legal && (w_phase == r_phase + PW'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_UNLOCKED;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (r_en) begin
            case (r_state)
                c_UNLOCKED: begin
                    if (w_legal) begin
                        w_state_nxt = c_LOCKING;
                        w_run_nxt   = RW'(1);
                    end
                end
                c_LOCKING: begin
                    if (w_inseq) begin
                        w_run_nxt = r_run + RW'(1);
                        if (r_run + RW'(1) == c_lock_cnt) begin
                            w_state_nxt = c_LOCKED;
                        end
                    end else if (w_legal) begin
                        w_run_nxt = RW'(1);
                    end else begin
                        w_state_nxt = c_UNLOCKED;
                        w_run_nxt   = '0;
                    end
                end
                c_LOCKED: begin
                    if (!w_inseq) begin
                        w_state_nxt = w_legal ? c_LOCKING : c_UNLOCKED;
                        w_run_nxt   = w_legal ? RW'(1) : '0;
                    end
                end
                default: begin
                    w_state_nxt = c_UNLOCKED;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // A clear coinciding with a new error leaves that error counted.
    always_comb begin
        w_seq_err_nxt = r_en && (r_state == c_LOCKED) && !w_inseq;
        w_wrap_nxt    = r_en && (r_state == c_LOCKED) && w_inseq && (w_phase == '0);
        if (CLR_ERR) begin
            w_err_nxt = w_seq_err_nxt ? ERRCNT_W'(1) : '0;
        end else if (w_seq_err_nxt && (r_err_cnt != c_err_max)) begin
            w_err_nxt = r_err_cnt + ERRCNT_W'(1);
        end else begin
            w_err_nxt = r_err_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_phase   <= '0;
            r_vld     <= 1'b0;
            r_legal   <= 1'b0;
            r_seq_err <= 1'b0;
            r_wrap    <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_vld     <= r_en;
            if (r_en) begin
                r_legal <= w_legal;
                if (w_legal) begin
                    r_phase <= w_phase;
                end
            end
            r_seq_err <= w_seq_err_nxt;
            r_wrap    <= w_wrap_nxt;
            r_locked  <= (w_state_nxt == c_LOCKED);
            r_err_cnt <= w_err_nxt;
        end
    end

    assign PHASE     = r_phase;
    assign PHASE_VLD = r_vld;
    assign LEGAL     = r_legal;
    assign SEQ_ERR   = r_seq_err;
    assign WRAP      = r_wrap;
    assign LOCKED    = r_locked;
    assign ERR_CNT   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 8-bit Johnson counter.
- Samples the counter's Johnson code and decodes it to a binary phase index 0..2*WIDTH-1.
- Flags illegal codes, checks that each sample is exactly one step ahead of the previous one, and tracks lock status.
- Reports wrap pulses and a saturating error count to control logic.

Parameters:
- WIDTH, 8: Johnson code width; power of 2, >=2. Number of phases = 2*WIDTH. Derived PW = clog2(2*WIDTH) = 4 at default.
- LOCK_CNT, 4: number of consecutive legal, in-sequence samples needed to enter LOCKED. The first sample of the run counts. Range 2..15.
- ERRCNT_W, 8: width of the error counter.

Ports:
- CLK  in  1  clock; all logic updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Q_IN  in  WIDTH  Johnson code from the counter.
- EN  in  1  sample strobe; Q_IN is accepted only on cycles where EN=1.
- CLR_ERR  in  1  synchronous clear of ERR_CNT.
- PHASE  out  PW  decoded phase of the most recent legal sample.
- PHASE_VLD  out  1  one-cycle pulse per accepted sample.
- LEGAL  out  1  high if the most recent accepted sample was a legal code.
- SEQ_ERR  out  1  one-cycle pulse on a sequence or legality error while LOCKED.
- WRAP  out  1  one-cycle pulse on an in-sequence transition from phase 2*WIDTH-1 to phase 0 while LOCKED.
- LOCKED  out  1  high while the FSM is in state LOCKED.
- ERR_CNT  out  ERRCNT_W  saturating count of SEQ_ERR pulses.

Behaviour:
- Reset (synchronous, dominates all other inputs): every output is 0. Internal registers are cleared: stage-1 registers, previous-phase register, run counter. FSM goes to UNLOCKED.
- Pipeline:
  - Stage 1: at edge k, Q_R <= Q_IN and EN_R <= EN.
  - Stage 2: at edge k+1, decode and update all outputs.
  - Outputs are visible after edge k+1, i.e. 2-cycle latency.
  - EN=0 samples are invisible: PHASE_VLD=0, and PHASE, LEGAL and FSM state are unchanged.
  - All outputs are registered.
- Legality:
  - MSB=0: legal iff Q = 2^n-1 for n = 0..WIDTH-1. Phase = n.
  - MSB=1: legal iff the ones are contiguous from the MSB, i.e. Q = ~(2^m-1) for m = 0..WIDTH-1. Phase = WIDTH+m.
  - Examples at WIDTH=8: 0x00->0, 0x01->1, 0x7F->7, 0xFF->8, 0xFE->9, 0x80->15.
- Illegal sample: LEGAL=0 and PHASE holds its last legal value.
- Legal sample: LEGAL=1 and PHASE is updated.
- In-sequence test: legal AND phase == (previous legal phase + 1) mod 2*WIDTH. A repeated phase is out of sequence.
- FSM, with run counter RUN:
  - UNLOCKED:
    - legal -> LOCKING, RUN=1.
    - illegal -> stay.
  - LOCKING:
    - in-sequence -> RUN+1; when RUN reaches LOCK_CNT, -> LOCKED, with LOCKED asserted together with that sample's outputs.
    - legal but out of sequence -> stay, RUN=1.
    - illegal -> UNLOCKED.
  - LOCKED:
    - in-sequence -> stay.
    - legal out of sequence -> SEQ_ERR pulse, -> LOCKING, RUN=1.
    - illegal -> SEQ_ERR pulse, -> UNLOCKED.
- SEQ_ERR is never asserted outside LOCKED.
- WRAP is asserted only for an in-sequence 2*WIDTH-1 -> 0 step while staying LOCKED.
- ERR_CNT:
  - increments on each SEQ_ERR and saturates at all-ones.
  - CLR_ERR alone sets it to 0.
  - CLR_ERR and SEQ_ERR in the same cycle give ERR_CNT=1.
- Reset mid-operation: a sample held in stage 1 is discarded and produces no PHASE_VLD.

Test Plan:
1. Reset, then EN=1 every cycle with Q_IN = 0xFF, 0xFE, 0xFC, 0xF8 -> PHASE 8, 9, 10, 11 on successive cycles starting 2 cycles later. PHASE_VLD=1, LEGAL=1, LOCKED rises together with PHASE=11, SEQ_ERR=0.
2. Continue through 0x80, 0x00, 0x01 -> WRAP pulses exactly once, in the cycle PHASE becomes 0. LOCKED stays 1, ERR_CNT=0.
3. LOCKED at PHASE=15, inject 0x5A -> LEGAL=0, PHASE holds 15, SEQ_ERR one-cycle pulse, ERR_CNT=1, LOCKED=0 (UNLOCKED). Then 4 consecutive legal in-sequence samples -> LOCKED=1 again.
4. LOCKED at phase 2 (0x03), next sample 0x0F -> PHASE=4, LEGAL=1, SEQ_ERR pulse, LOCKED=0. Relock occurs after 3 further in-sequence samples (5, 6, 7).
5. EN toggling 1,0,0,1 with Q_IN changing while EN=0 -> only EN=1 samples produce PHASE_VLD, no errors. Two EN=1 samples of 0x07 while LOCKED -> SEQ_ERR.
6. ERRCNT_W=2: force 4 errors -> ERR_CNT=3 (saturated). Assert CLR_ERR in the same cycle as a SEQ_ERR -> ERR_CNT=1. Assert RESET mid-LOCKED -> all outputs 0 on the next edge.
